// File: rtl/flag_unit.sv
// Z/V/N condition-flag register, sticky overflow and branch-condition resolver for the EX stage.
// Latency: flags update on the clock edge after commit; br_taken is combinational, with optional EX bypass.
// Backpressure: stall freezes the flag state (ovfl_clr still acts); flush kills the EX update and bypass.
module flag_unit #(
   parameter int WIDTH  = 16,
   parameter bit BYPASS = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic [3:0]       ex_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_ovfl,
   input  logic             stall,
   input  logic             flush,
   input  logic             br_eval,
   input  logic [2:0]       br_cond,
   input  logic             ovfl_clr,
   output logic             flag_z,
   output logic             flag_v,
   output logic             flag_n,
   output logic             ovfl_sticky,
   output logic             br_taken
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;

   localparam logic [2:0] BR_NE  = 3'b000;
   localparam logic [2:0] BR_EQ  = 3'b001;
   localparam logic [2:0] BR_GT  = 3'b010;
   localparam logic [2:0] BR_LT  = 3'b011;
   localparam logic [2:0] BR_GE  = 3'b100;
   localparam logic [2:0] BR_LE  = 3'b101;
   localparam logic [2:0] BR_OV  = 3'b110;

   logic upd;
   logic op_arith;   // writes Z, N and V
   logic op_logic;   // writes Z only
   logic z_next;
   logic n_next;
   logic v_next;
   logic sticky_set;
   logic byp_arith;
   logic byp_any;
   logic ez;
   logic ev;
   logic en;
   logic cond_result;

   assign upd      = ex_valid & ~stall & ~flush;
   assign op_arith = (ex_op == OP_ADD) || (ex_op == OP_SUB);
   assign op_logic = (ex_op == OP_XOR) || (ex_op == OP_SLL) ||
                     (ex_op == OP_SRA) || (ex_op == OP_ROR);

   assign z_next = (alu_out == '0);
   assign n_next = alu_out[WIDTH-1];
   assign v_next = alu_ovfl;

   // Overflow only counts for committed arithmetic; other opcodes ignore alu_ovfl.
   assign sticky_set = upd & op_arith & alu_ovfl;

   // Flag register: arithmetic writes all three flags, logic/shift ops only Z.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z <= 1'b0;
         flag_v <= 1'b0;
         flag_n <= 1'b0;
      end else if (upd && op_arith) begin
         flag_z <= z_next;
         flag_v <= v_next;
         flag_n <= n_next;
      end else if (upd && op_logic) begin
         flag_z <= z_next;
      end
   end

   // Sticky overflow: set dominates clear; clear is honoured even while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovfl_sticky <= 1'b0;
      end else if (sticky_set) begin
         ovfl_sticky <= 1'b1;
      end else if (ovfl_clr) begin
         ovfl_sticky <= 1'b0;
      end
   end

   // Effective flags: forward next-state values only for flags the EX op actually writes.
   assign byp_arith = BYPASS & upd & op_arith;
   assign byp_any   = BYPASS & upd & (op_arith | op_logic);

   assign ez = byp_any   ? z_next : flag_z;
   assign en = byp_arith ? n_next : flag_n;
   assign ev = byp_arith ? v_next : flag_v;

   // Branch condition decode; purely combinational, feeds no register.
   always_comb begin
      cond_result = 1'b0;
      case (br_cond)
         BR_NE:   cond_result = ~ez;
         BR_EQ:   cond_result = ez;
         BR_GT:   cond_result = ~ez & ~en;
         BR_LT:   cond_result = en;
         BR_GE:   cond_result = ez | (~ez & ~en);
         BR_LE:   cond_result = en | ez;
         BR_OV:   cond_result = ev;
         default: cond_result = 1'b1;
      endcase
   end

   assign br_taken = br_eval & cond_result;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: drives directed vectors into a bypassing and a non-bypassing instance.
// Each vector pushes hand-computed expected outputs; a negedge monitor pops and compares them.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_flag_unit;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [15:0] alu_out;
   logic        alu_ovfl;
   logic        stall;
   logic        flush;
   logic        br_eval;
   logic [2:0]  br_cond;
   logic        ovfl_clr;

   logic flag_z1, flag_v1, flag_n1, sticky1, br_taken1;
   logic flag_z0, flag_v0, flag_n0, sticky0, br_taken0;

   logic chk;
   logic [5:0] exp_q[$];   // {z, v, n, sticky, br_taken(BYPASS=1), br_taken(BYPASS=0)}
   string      name_q[$];

   int n_cmp;
   int n_bad;

   flag_unit #(.WIDTH(16), .BYPASS(1'b1)) dut_byp (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
      .alu_out(alu_out), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
      .br_eval(br_eval), .br_cond(br_cond), .ovfl_clr(ovfl_clr),
      .flag_z(flag_z1), .flag_v(flag_v1), .flag_n(flag_n1),
      .ovfl_sticky(sticky1), .br_taken(br_taken1)
   );

   flag_unit #(.WIDTH(16), .BYPASS(1'b0)) dut_nobyp (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
      .alu_out(alu_out), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
      .br_eval(br_eval), .br_cond(br_cond), .ovfl_clr(ovfl_clr),
      .flag_z(flag_z0), .flag_v(flag_v0), .flag_n(flag_n0),
      .ovfl_sticky(sticky0), .br_taken(br_taken0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: whenever a vector is presented, pop its expectation and compare.
   always @(negedge clk) begin
      if (chk) begin
         logic [5:0] act;
         logic [5:0] expv;
         string      nm;
         act = {flag_z1, flag_v1, flag_n1, sticky1, br_taken1, br_taken0};
         n_cmp = n_cmp + 1;
         if (exp_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL scoreboard_empty: got zvns_bt1_bt0=%b, no expectation queued", act);
         end else begin
            expv = exp_q.pop_front();
            nm   = name_q.pop_front();
            if (act !== expv ||
                {flag_z0, flag_v0, flag_n0, sticky0} !== expv[5:2]) begin
               n_bad = n_bad + 1;
               $display("FAIL %s: got zvns_bt1_bt0=%b (nobyp zvns=%b), expected %b",
                        nm, act, {flag_z0, flag_v0, flag_n0, sticky0}, expv);
            end
         end
      end
   end

   // One cycle of stimulus; ex = {z, v, n, sticky, bt_bypass, bt_nobypass} seen this cycle.
   task automatic cyc(input string nm, input logic v, input logic [3:0] op,
                      input logic [15:0] a, input logic ov, input logic st,
                      input logic fl, input logic be, input logic [2:0] bc,
                      input logic clr, input logic mid_rst, input logic [5:0] ex);
      @(posedge clk);
      #1;
      ex_valid = v;
      ex_op    = op;
      alu_out  = a;
      alu_ovfl = ov;
      stall    = st;
      flush    = fl;
      br_eval  = be;
      br_cond  = bc;
      ovfl_clr = clr;
      exp_q.push_back(ex);
      name_q.push_back(nm);
      chk = 1'b1;
      if (mid_rst) begin
         #2;
         rst_n = 1'b0;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      chk = 1'b0;
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_op = 4'h0; alu_out = 16'h0; alu_ovfl = 1'b0;
      stall = 1'b0; flush = 1'b0; br_eval = 1'b0; br_cond = 3'b000; ovfl_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      //   name           v  op     alu       ov st fl be cond  clr rst  z v n s b1 b0
      cyc("rst_ne",       0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 0, 0, 6'b0000_11);
      cyc("rst_eq",       0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd1, 0, 0, 6'b0000_00);
      cyc("add_ovfl",     1, 4'h0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 0, 6'b0000_00);
      cyc("after_add",    0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 1, 0, 6'b1101_00);
      cyc("sub_byp_eq",   1, 4'h1, 16'h8001, 0, 0, 0, 1, 3'd1, 0, 0, 6'b1100_01);
      cyc("xor_byp_le",   1, 4'h3, 16'h0000, 0, 0, 0, 1, 3'd5, 0, 0, 6'b0010_11);
      cyc("le_taken",     0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd5, 0, 0, 6'b1010_11);
      cyc("gt_not",       0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd2, 0, 0, 6'b1010_00);
      cyc("add_pos",      1, 4'h0, 16'h0005, 0, 0, 0, 0, 3'd0, 0, 0, 6'b1010_00);
      cyc("flush_eq",     1, 4'h1, 16'h0000, 0, 0, 1, 1, 3'd1, 0, 0, 6'b0000_00);
      cyc("sub_byp_eq2",  1, 4'h1, 16'h0000, 0, 0, 0, 1, 3'd1, 0, 0, 6'b0000_10);
      cyc("after_sub",    0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 6'b1000_00);
      cyc("stall_add",    1, 4'h0, 16'hFFFF, 1, 1, 0, 1, 3'd1, 0, 0, 6'b1000_11);
      cyc("paddsb_ov",    1, 4'h7, 16'h0000, 1, 0, 0, 1, 3'd6, 0, 0, 6'b1000_00);
      cyc("unc",          0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd7, 0, 0, 6'b1000_11);
      cyc("add_set_clr",  1, 4'h0, 16'h8000, 1, 0, 0, 0, 3'd0, 1, 0, 6'b1000_00);
      cyc("stall_clr",    0, 4'h0, 16'h0000, 0, 1, 0, 0, 3'd0, 1, 0, 6'b0111_00);
      cyc("ov_taken",     0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd6, 0, 0, 6'b0110_11);
      cyc("sll_byp_ne",   1, 4'h4, 16'h0000, 1, 0, 0, 1, 3'd0, 0, 0, 6'b0110_01);
      cyc("red_ge",       1, 4'h2, 16'h0005, 0, 0, 0, 1, 3'd4, 0, 0, 6'b1110_11);
      cyc("ror_byp_ge",   1, 4'h6, 16'h0001, 0, 0, 0, 1, 3'd4, 0, 0, 6'b1110_01);
      cyc("op10xx_lt",    1, 4'hA, 16'h0000, 1, 0, 0, 1, 3'd3, 0, 0, 6'b0110_11);
      cyc("add_byp_eq",   1, 4'h0, 16'h8000, 1, 0, 0, 1, 3'd1, 0, 0, 6'b0110_00);
      cyc("sra_zero",     1, 4'h5, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 6'b0111_00);
      cyc("all_set",      0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 0, 0, 6'b1111_00);
      cyc("async_rst",    0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 0, 1, 6'b0000_11);

      @(posedge clk);
      #1;
      chk = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
